// File: rtl/abm_responder.sv
`default_nettype none
// abm_responder: AXI4 slave owning the 512-bit ABM sample buffer RAM.
// Independent write and read burst engines; reads stream through a 2-entry prefetch buffer.
module abm_responder #(
  parameter int DW         = 512,
  parameter int AW         = 64,
  parameter int DEPTH_LOG2 = 14,
  parameter int IDW        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     S_AXI_AWADDR,
  input  logic [7:0]        S_AXI_AWLEN,
  input  logic [2:0]        S_AXI_AWSIZE,
  input  logic [1:0]        S_AXI_AWBURST,
  input  logic [IDW-1:0]    S_AXI_AWID,
  input  logic              S_AXI_AWLOCK,
  input  logic [3:0]        S_AXI_AWCACHE,
  input  logic [3:0]        S_AXI_AWQOS,
  input  logic [2:0]        S_AXI_AWPROT,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [DW-1:0]     S_AXI_WDATA,
  input  logic [DW/8-1:0]   S_AXI_WSTRB,
  input  logic              S_AXI_WLAST,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [AW-1:0]     S_AXI_ARADDR,
  input  logic [7:0]        S_AXI_ARLEN,
  input  logic [2:0]        S_AXI_ARSIZE,
  input  logic [1:0]        S_AXI_ARBURST,
  input  logic [IDW-1:0]    S_AXI_ARID,
  input  logic              S_AXI_ARLOCK,
  input  logic [3:0]        S_AXI_ARCACHE,
  input  logic [3:0]        S_AXI_ARQOS,
  input  logic [2:0]        S_AXI_ARPROT,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [DW-1:0]     S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RLAST,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY
);
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_BUSY = 1'b1;

  logic [DW-1:0]         mem [DEPTH];
  logic [DW-1:0]         ram_q;

  logic [1:0]            wr_state;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [8:0]            wr_cnt;
  logic                  wr_err;
  logic                  aw_hs, w_hs, b_hs, wr_final;

  logic [0:0]            rd_state;
  logic [DEPTH_LOG2-1:0] rd_idx, rd_addr, ar_idx;
  logic [8:0]            rd_issue_left, rd_beats_left;
  logic                  rd_pending;
  logic [1:0]            buf_cnt;
  logic [DW-1:0]         buf0, buf1;
  logic                  ar_hs, r_pop, rd_issue, rd_en;

  assign S_AXI_AWREADY = !reset && (wr_state == W_IDLE);
  assign S_AXI_WREADY  = !reset && (wr_state == W_DATA);
  assign S_AXI_BVALID  = !reset && (wr_state == W_RESP);
  assign S_AXI_BRESP   = (S_AXI_BVALID && wr_err) ? 2'b10 : 2'b00;
  assign aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs     = S_AXI_WVALID && S_AXI_WREADY;
  assign b_hs     = S_AXI_BVALID && S_AXI_BREADY;
  assign wr_final = (wr_cnt == 9'd1);

  // The beat count alone ends the burst; WLAST only feeds the error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= W_IDLE;
      wr_idx   <= '0;
      wr_cnt   <= '0;
      wr_err   <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: if (aw_hs) begin
          wr_idx   <= S_AXI_AWADDR[DEPTH_LOG2+5:6];
          wr_cnt   <= {1'b0, S_AXI_AWLEN} + 9'd1;
          wr_err   <= 1'b0;
          wr_state <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          wr_idx <= wr_idx + IDX_ONE;
          wr_cnt <= wr_cnt - 9'd1;
          if (S_AXI_WLAST != wr_final) wr_err <= 1'b1;
          if (wr_final) wr_state <= W_RESP;
        end
        W_RESP: if (b_hs) wr_state <= W_IDLE;
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read-first: a same-cycle read of the word being written sees the old contents.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int b = 0; b < NB; b++) begin
        if (S_AXI_WSTRB[b]) mem[wr_idx][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
      end
    end
    if (rd_en) ram_q <= mem[rd_addr];
  end

  assign ar_idx        = S_AXI_ARADDR[DEPTH_LOG2+5:6];
  assign S_AXI_ARREADY = !reset && (rd_state == R_IDLE);
  assign S_AXI_RVALID  = !reset && (buf_cnt != 2'd0);
  assign S_AXI_RLAST   = S_AXI_RVALID && (rd_beats_left == 9'd1);
  assign S_AXI_RDATA   = reset ? '0 : buf0;
  assign S_AXI_RRESP   = 2'b00;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_pop = S_AXI_RVALID && S_AXI_RREADY;
  // First word is fetched on the AR handshake itself; later fetches only when the
  // buffer is certain to have room when the word arrives a cycle later.
  assign rd_issue = (rd_state == R_BUSY) && (rd_issue_left != 9'd0) &&
                    (({1'b0, buf_cnt} + {2'b00, rd_pending} - {2'b00, r_pop}) < 3'd2);
  assign rd_en   = ar_hs || rd_issue;
  assign rd_addr = (rd_state == R_IDLE) ? ar_idx : rd_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state      <= R_IDLE;
      rd_idx        <= '0;
      rd_issue_left <= '0;
      rd_beats_left <= '0;
      rd_pending    <= 1'b0;
      buf_cnt       <= 2'd0;
      buf0          <= '0;
      buf1          <= '0;
    end else begin
      rd_pending <= rd_en;
      case (rd_state)
        R_IDLE: if (ar_hs) begin
          rd_idx        <= ar_idx + IDX_ONE;
          rd_issue_left <= {1'b0, S_AXI_ARLEN};
          rd_beats_left <= {1'b0, S_AXI_ARLEN} + 9'd1;
          rd_state      <= R_BUSY;
        end
        default: begin
          if (rd_issue) begin
            rd_idx        <= rd_idx + IDX_ONE;
            rd_issue_left <= rd_issue_left - 9'd1;
          end
          if (r_pop) begin
            rd_beats_left <= rd_beats_left - 9'd1;
            if (rd_beats_left == 9'd1) rd_state <= R_IDLE;
          end
        end
      endcase
      case ({r_pop, rd_pending})
        2'b01: begin
          if (buf_cnt == 2'd0) buf0 <= ram_q;
          else                 buf1 <= ram_q;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b10: begin
          buf0    <= buf1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) buf0 <= ram_q;
          else begin
            buf0 <= buf1;
            buf1 <= ram_q;
          end
        end
        default: ;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWADDR, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWID, S_AXI_AWLOCK,
                       S_AXI_AWCACHE, S_AXI_AWQOS, S_AXI_AWPROT, S_AXI_ARADDR, S_AXI_ARSIZE,
                       S_AXI_ARBURST, S_AXI_ARID, S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARQOS,
                       S_AXI_ARPROT};
endmodule
`default_nettype wire

// File: tb/tb_abm_responder.sv
`default_nettype none
// tb_abm_responder: directed scoreboard bench for abm_responder.
module tb_abm_responder;
  localparam int DW = 512, AW = 64, DL = 14, NB = 64, TMO = 400;

  logic clk = 1'b0, reset = 1'b1;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [7:0] awlen = '0, arlen = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, arvalid = 1'b0;
  logic bready = 1'b1, rready = 1'b1;
  logic [DW-1:0] wdata = '0;
  logic [NB-1:0] wstrb = '1;
  logic awready, wready, bvalid, arready, rvalid, rlast;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata;

  abm_responder dut (
    .clk(clk), .reset(reset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(3'd6), .S_AXI_AWBURST(2'b01),
    .S_AXI_AWID(4'd0), .S_AXI_AWLOCK(1'b0), .S_AXI_AWCACHE(4'd0), .S_AXI_AWQOS(4'd0),
    .S_AXI_AWPROT(3'd0), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(3'd6), .S_AXI_ARBURST(2'b01),
    .S_AXI_ARID(4'd0), .S_AXI_ARLOCK(1'b0), .S_AXI_ARCACHE(4'd0), .S_AXI_ARQOS(4'd0),
    .S_AXI_ARPROT(3'd0), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  int last_r_cyc = -1, t_tmp;
  logic [DW:0]   exp_r[$];
  logic [1:0]    exp_b[$];
  logic [DW-1:0] model [0:(1<<DL)-1];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [DL-1:0] idx_of(input logic [AW-1:0] a);
    return a[DL+5:6];
  endfunction

  function automatic logic [DW-1:0] pat(input logic [31:0] b);
    return {16{b}};
  endfunction

  function automatic logic ready_of(input int ch);
    case (ch)
      0: return awready;
      1: return wready;
      2: return arready;
      default: return 1'b0;
    endcase
  endfunction

  // Called at #1 after a posedge; returns #1 after the edge that completed the handshake.
  task automatic hs(input int ch, input string nm, output int t);
    bit ok;
    ok = 0;
    t = -1;
    for (int k = 0; k < TMO && !ok; k++) begin
      @(negedge clk);
      if (ready_of(ch)) begin
        ok = 1;
        t = cyc;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL %s handshake: got timeout, required ready", nm);
    end
  endtask

  task automatic wait_drain(input string nm);
    int k;
    k = 0;
    while ((exp_r.size() != 0 || exp_b.size() != 0) && k < TMO) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= TMO) begin
      n_cmp++; n_err++;
      $display("FAIL %s drain: got %0d R / %0d B outstanding, required 0", nm, exp_r.size(), exp_b.size());
    end
  endtask

  task automatic write_burst(input logic [AW-1:0] addr, input logic [7:0] len, input logic [31:0] base,
                             input logic [NB-1:0] strb, input int last_pos, input logic [1:0] resp,
                             input bit timed);
    int t_aw, t_w, t_w0;
    logic [DL-1:0] ix;
    logic [DW-1:0] d;
    exp_b.push_back(resp);
    ix = idx_of(addr);
    for (int i = 0; i <= int'(len); i++) begin
      d = pat(base + 32'(i));
      for (int b = 0; b < NB; b++) if (strb[b]) model[ix][b*8 +: 8] = d[b*8 +: 8];
      ix = ix + 1'b1;
    end
    awaddr = addr; awlen = len; awvalid = 1'b1;
    hs(0, "aw", t_aw);
    awvalid = 1'b0;
    t_w0 = -1;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = pat(base + 32'(i)); wstrb = strb; wlast = (i == last_pos); wvalid = 1'b1;
      hs(1, "w", t_w);
      if (i == 0) t_w0 = t_w;
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (timed) begin
      check("wready_at_aw_plus1", t_w0, t_aw + 1);
      @(negedge clk);
      check("bvalid_at_lastw_plus1", bvalid, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check("awready_after_b", awready, 1'b1);
      @(posedge clk); #1;
    end
    wait_drain("write");
  endtask

  // mode 0 plain, 1 cycle-checked, 2 throttled RREADY, 3 return right after AR
  task automatic read_burst(input logic [AW-1:0] addr, input logic [7:0] len, input int mode);
    int t_ar, t_v;
    logic [DL-1:0] ix;
    logic [31:0] thr;
    thr = 32'b1011_0010_0111_0100_1100_0101_1010_0011;
    ix = idx_of(addr);
    for (int i = 0; i <= int'(len); i++) begin
      exp_r.push_back({(i == int'(len)), model[ix]});
      ix = ix + 1'b1;
    end
    araddr = addr; arlen = len; arvalid = 1'b1;
    hs(2, "ar", t_ar);
    arvalid = 1'b0;
    if (mode == 1) begin
      t_v = -1;
      for (int k = 0; k < 8 && t_v < 0; k++) begin
        @(negedge clk);
        if (rvalid) t_v = cyc;
        @(posedge clk); #1;
      end
      check("first_rvalid_cycle", t_v, t_ar + 2);
    end
    if (mode == 2) begin
      for (int k = 0; k < TMO && exp_r.size() != 0; k++) begin
        rready = thr[k % 32];
        @(posedge clk); #1;
      end
      rready = 1'b1;
    end
    if (mode != 3) wait_drain("read");
    if (mode == 1) check("burst_done_cycle", last_r_cyc, t_ar + int'(len) + 2);
  endtask

  // Monitor: pops the scoreboard on each R/B handshake and checks stall stability.
  logic [DW:0]   m_e;
  logic [1:0]    m_b;
  logic          prev_stall = 1'b0, prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (prev_stall) begin
          check("stall_rvalid", rvalid, 1'b1);
          check("stall_rdata", rdata, prev_data);
          check("stall_rlast", rlast, prev_last);
        end
        if (rvalid && rready) begin
          if (exp_r.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL r_unexpected: got beat %0h, required none", rdata);
          end else begin
            m_e = exp_r.pop_front();
            check("rdata", rdata, m_e[DW-1:0]);
            check("rlast", rlast, m_e[DW]);
            check("rresp", rresp, 2'b00);
            if (rlast) last_r_cyc = cyc;
          end
        end
        if (bvalid && bready) begin
          if (exp_b.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL b_unexpected: got bresp %0h, required none", bresp);
          end else begin
            m_b = exp_b.pop_front();
            check("bresp", bresp, m_b);
          end
        end
      end
      prev_stall = rvalid && !rready && !reset;
      prev_data  = rdata;
      prev_last  = rlast;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required summary");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", {bvalid, bresp}, 3'b000);
    check("rst_arready", arready, 1'b0);
    check("rst_rvalid", {rvalid, rlast, rresp}, 4'b0000);
    check("rst_rdata", rdata, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_awready", awready, 1'b1);
    check("post_arready", arready, 1'b1);
    check("post_quiet", {wready, bvalid, rvalid, rlast}, 4'b0000);
    check("post_rdata", rdata, '0);
    @(posedge clk); #1;

    write_burst(64'h40, 8'd0, 32'hA5A5_0001, '1, 0, 2'b00, 1'b1);
    read_burst(64'h40, 8'd0, 1);

    write_burst(64'h1000, 8'd63, 32'h1000_0000, '1, 63, 2'b00, 1'b1);
    read_burst(64'h1000, 8'd63, 1);
    read_burst(64'h1000, 8'd15, 2);

    write_burst(64'h2000, 8'd0, 32'hFFFF_FFFF, '1, 0, 2'b00, 1'b0);
    write_burst(64'h2000, 8'd0, 32'h0000_0000, 64'h0F, 0, 2'b00, 1'b0);
    read_burst(64'h2000, 8'd0, 0);

    write_burst(64'h3000, 8'd3, 32'hE000_0000, '1, 1, 2'b10, 1'b0);
    write_burst(64'h3000, 8'd3, 32'hE100_0000, '1, 3, 2'b00, 1'b0);
    write_burst(64'h3000, 8'd1, 32'hE200_0000, '1, -1, 2'b10, 1'b0);
    read_burst(64'h3000, 8'd3, 0);

    write_burst(64'hF_FFC0, 8'd1, 32'hC0DE_0000, '1, 1, 2'b00, 1'b0);
    read_burst(64'h0, 8'd0, 0);
    read_burst(64'hF_FFC0, 8'd1, 0);
    read_burst(64'hF000_0000_0000_0047, 8'd0, 0);

    fork
      write_burst(64'h4000, 8'd7, 32'hB000_0000, '1, 7, 2'b00, 1'b0);
      read_burst(64'h1000, 8'd7, 0);
    join
    read_burst(64'h4000, 8'd7, 0);

    // Same-cycle write and read of word 1: read must return the old contents.
    exp_b.push_back(2'b00);
    exp_r.push_back({1'b1, model[1]});
    awaddr = 64'h40; awlen = 8'd0; awvalid = 1'b1;
    hs(0, "aw_coll", t_tmp);
    awvalid = 1'b0;
    wdata = pat(32'h5A5A_0002); wstrb = '1; wlast = 1'b1; wvalid = 1'b1;
    araddr = 64'h40; arlen = 8'd0; arvalid = 1'b1;
    @(negedge clk);
    check("collide_ready", {wready, arready}, 2'b11);
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    model[1] = pat(32'h5A5A_0002);
    wait_drain("collide");
    read_burst(64'h40, 8'd0, 0);

    read_burst(64'h1000, 8'd7, 3);
    for (int k = 0; k < TMO && exp_r.size() > 4; k++) begin
      @(posedge clk); #1;
    end
    check("mid_reset_beats_left", exp_r.size(), 4);
    reset = 1'b1;
    exp_r.delete();
    @(negedge clk);
    check("rst_mid_rvalid", rvalid, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("after_rst_rvalid", rvalid, 1'b0);
    check("after_rst_ready", {arready, awready}, 2'b11);
    @(posedge clk); #1;
    read_burst(64'h1040, 8'd3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
